// File: rtl/mfp_ahb_cube_bank.sv
// mfp_ahb_cube_bank: AHB-Lite slave that holds the virtual Rubik's cube faces, runs the
// START/ACK/DONE renderer handshake and queues PMOD move codes in a FIFO that the CPU drains.
//
// Ports:
//   HCLK, HRESETn           clock, asynchronous active-low reset
//   HADDR/HTRANS/HWDATA/
//   HWRITE/HSEL/HRDATA      AHB-Lite slave (word index HADDR[7:2], zero wait states)
//   IO_FACES                face i at [i*FW +: FW], FW = STICKERS*COLOR_W
//   IO_START/IO_ACK/IO_DONE renderer handshake
//   IO_MOVE/IO_MOVE_VLD     asynchronous PMOD move code and strobe
//   IO_IRQ                  high while the move FIFO is non-empty or IO_DONE is set
//
// Build option: define MFP_CUBE_READBACK_EN to make FACE registers readable;
// otherwise FACE reads return 0.
module mfp_ahb_cube_bank #(
    parameter int N_FACE     = 6,
    parameter int STICKERS   = 9,
    parameter int COLOR_W    = 3,
    parameter int MOVE_W     = 5,
    parameter int MOVE_DEPTH = 8
) (
    input  logic                                 HCLK,
    input  logic                                 HRESETn,
    input  logic [31:0]                          HADDR,
    input  logic [1:0]                           HTRANS,
    input  logic [31:0]                          HWDATA,
    input  logic                                 HWRITE,
    input  logic                                 HSEL,
    output logic [31:0]                          HRDATA,
    output logic [N_FACE*STICKERS*COLOR_W-1:0]   IO_FACES,
    output logic                                 IO_START,
    input  logic                                 IO_ACK,
    output logic                                 IO_DONE,
    input  logic [MOVE_W-1:0]                    IO_MOVE,
    input  logic                                 IO_MOVE_VLD,
    output logic                                 IO_IRQ
);
    localparam int FW = STICKERS * COLOR_W;
    localparam int AW = $clog2(MOVE_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t                r_state, w_state_nx;
    logic                  r_done, w_done_nx;
    logic [5:0]            r_addr;
    logic                  r_sel, r_wr;
    logic [1:0]            r_trans;
    logic [FW-1:0]         r_face [N_FACE];
    logic                  r_vld_s1, r_vld_s2, r_vld_d;
    logic [MOVE_W-1:0]     r_mv_s1, r_mv_s2;
    logic [MOVE_W-1:0]     r_mem [MOVE_DEPTH];
    logic [PW-1:0]         r_wp, r_rp;
    logic                  r_ovf;

    logic                  w_we, w_ctrl_wr, w_flush, w_rd, w_push, w_pop, w_push_ok;
    logic                  w_empty, w_full;
    logic [PW-1:0]         w_count;
    logic [5:0]            w_raddr;
    logic [31:0]           w_status, w_move_word, w_rdata;
    logic                  w_unused;

    assign w_unused    = ^{HADDR, HWDATA};
    assign w_we        = (r_trans != 2'b00) && r_sel && r_wr;
    assign w_ctrl_wr   = w_we && (r_addr == 6'h10);
    assign w_flush     = w_ctrl_wr && HWDATA[2];
    assign w_raddr     = HADDR[7:2];
    assign w_rd        = HSEL && (HTRANS != 2'b00) && !HWRITE;
    assign w_count     = r_wp - r_rp;
    assign w_empty     = (r_wp == r_rp);
    assign w_full      = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    // A MOVE read pops in its address phase, at the same edge that registers HRDATA.
    assign w_pop       = w_rd && (w_raddr == 6'h12) && !w_empty;
    assign w_push      = r_vld_s2 && !r_vld_d;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_status    = {16'b0, 8'(w_count), 4'b0, r_ovf, w_full, r_done, IO_START};
    assign w_move_word = {1'b1, {(31-MOVE_W){1'b0}}, r_mem[r_rp[AW-1:0]]};
    assign IO_START    = (r_state == S_REQ);
    assign IO_DONE     = r_done;
    assign IO_IRQ      = !w_empty || r_done;

    for (genvar g = 0; g < N_FACE; g++) begin : g_face
        assign IO_FACES[g*FW +: FW] = r_face[g];
    end

    always_comb begin
        w_rdata = '0;
        if (w_raddr == 6'h11) w_rdata = w_status;
        if (w_raddr == 6'h12 && !w_empty) w_rdata = w_move_word;
`ifdef MFP_CUBE_READBACK_EN
        for (int i = 0; i < N_FACE; i++)
            if (w_raddr == 6'(i)) w_rdata = 32'(r_face[i]);
`endif
    end

    // An ACK in the same cycle as a DONE-clear write wins because it is applied last.
    always_comb begin
        w_state_nx = r_state;
        w_done_nx  = r_done;
        if (w_ctrl_wr && HWDATA[1]) w_done_nx = 1'b0;
        if (r_state == S_IDLE && w_ctrl_wr && HWDATA[0]) w_state_nx = S_REQ;
        if (r_state == S_REQ && IO_ACK) begin
            w_state_nx = S_IDLE;
            w_done_nx  = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= S_IDLE;
            r_done   <= 1'b0;
            r_addr   <= '0;
            r_sel    <= 1'b0;
            r_wr     <= 1'b0;
            r_trans  <= 2'b00;
            HRDATA   <= '0;
            r_vld_s1 <= 1'b0;
            r_vld_s2 <= 1'b0;
            r_vld_d  <= 1'b0;
            r_mv_s1  <= '0;
            r_mv_s2  <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < N_FACE; i++)
                for (int j = 0; j < STICKERS; j++)
                    r_face[i][j*COLOR_W +: COLOR_W] <= COLOR_W'(i);
        end else begin
            r_state  <= w_state_nx;
            r_done   <= w_done_nx;
            r_addr   <= HADDR[7:2];
            r_sel    <= HSEL;
            r_wr     <= HWRITE;
            r_trans  <= HTRANS;
            HRDATA   <= w_rd ? w_rdata : '0;
            r_vld_s1 <= IO_MOVE_VLD;
            r_vld_s2 <= r_vld_s1;
            r_vld_d  <= r_vld_s2;
            r_mv_s1  <= IO_MOVE;
            r_mv_s2  <= r_mv_s1;
            for (int i = 0; i < N_FACE; i++)
                if (w_we && r_addr == 6'(i)) r_face[i] <= HWDATA[FW-1:0];
            if (w_flush) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_push_ok) r_wp <= r_wp + 1'b1;
                if (w_pop) r_rp <= r_rp + 1'b1;
                if (w_push && !w_push_ok) r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK)
        if (w_push_ok && !w_flush) r_mem[r_wp[AW-1:0]] <= r_mv_s2;
endmodule

// File: doc/mfp_ahb_cube_bank.md
# mfp_ahb_cube_bank

Parametrised AHB-Lite slave for the MIPSfpga virtual Rubik's cube.
- Holds `N_FACE` face registers and drives them flattened to the cube renderer; the CPU can read them back.
- Runs a START/ACK/DONE handshake with the renderer.
- Buffers move codes from the Wi-Fi PMOD (NodeMCU) in a small FIFO that the CPU drains, so no moves are lost between polls.
- Sits on the AHB decoder next to the GPIO and 7-segment slaves.

## Interface
Parameters:
- `N_FACE`, 6: number of faces (1..16).
- `STICKERS`, 9: stickers per face.
- `COLOR_W`, 3: bits per sticker. Face width `FW = STICKERS*COLOR_W` must be ≤ 32.
- `MOVE_W`, 5: move code width.
- `MOVE_DEPTH`, 8: FIFO depth, a power of two, ≥ 2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `HCLK` in 1: clock.
- `HRESETn` in 1: asynchronous, active-low reset.
- `HADDR` in 32: AHB address; only `HADDR[7:2]` is decoded.
- `HTRANS` in 2: AHB transfer type.
- `HWDATA` in 32: write data.
- `HWRITE` in 1: AHB write strobe.
- `HSEL` in 1: slave select.
- `HRDATA` out 32: read data.
- `IO_FACES` out `N_FACE*FW`: face i occupies bits `[i*FW +: FW]`.
- `IO_START` out 1: render request.
- `IO_ACK` in 1: renderer completion pulse, synchronous to HCLK.
- `IO_DONE` out 1: sticky done flag.
- `IO_MOVE` in `MOVE_W`: PMOD move code (asynchronous).
- `IO_MOVE_VLD` in 1: PMOD strobe (asynchronous); the code is stable while it is high.
- `IO_IRQ` out 1: level interrupt, high while FIFO not empty OR `IO_DONE`.

## Operation
Register map (word index = `HADDR[7:2]`):
- 0..`N_FACE`-1 FACE[i], RW: sticker j is at bits `[j*COLOR_W +: COLOR_W]`; bits above FW are ignored on write and read as 0.
- 0x10 CTRL, W:
  - bit0 = 1 sets `IO_START`.
  - bit1 = 1 clears `IO_DONE`.
  - bit2 = 1 flushes the FIFO and clears OVF.
- 0x11 STATUS, R: `{16'b0, count[7:0], 4'b0, OVF, FULL, DONE, BUSY}`. BUSY = `IO_START`.
- 0x12 MOVE, R: `{VALID, 26'b0, code}`. A read while the FIFO is non-empty pops one entry; a read while empty returns 0 and pops nothing.
- Unmapped reads return 0; unmapped writes are ignored.

Write path:
- Address, HWRITE, HSEL and HTRANS are registered; the write commits in the data phase when the registered HTRANS ≠ IDLE, HSEL = 1 and HWRITE = 1.

Handshake state machine, IDLE → REQ → IDLE:
- A CTRL.bit0 write in IDLE enters REQ: `IO_START` = 1.
- In REQ, `IO_ACK` = 1 sets `IO_START` = 0 and `IO_DONE` = 1, then returns to IDLE.
- A CTRL.bit0 write while in REQ is ignored.
- `IO_ACK` in IDLE is ignored.
- An ACK and a CTRL.bit1 write in the same cycle leave `IO_DONE` = 1; the set wins.

Move capture:
- `IO_MOVE_VLD` passes through a 2-flop synchroniser plus an edge register; a rising edge pushes the synchronised `IO_MOVE`.
- `IO_MOVE` is sampled through a 2-flop synchroniser aligned with the valid path.

FIFO:
- Circular buffer with `$clog2(MOVE_DEPTH)+1`-bit pointers; pointers wrap modulo 2×depth. Full when the MSBs differ and the low bits are equal.
- A push while full without a simultaneous pop is dropped and sets OVF (sticky).
- A push and a pop in the same cycle when full both succeed and count is unchanged.
- A push and a pop in the same cycle when empty: the pop returns VALID = 0 and the push is stored.
- Flush and push in the same cycle: flush wins.

Reset values:
- FACE[i]: every sticker = i mod 2^COLOR_W (solved cube).
- `IO_START` = 0, `IO_DONE` = 0, FIFO empty, OVF = 0, `HRDATA` = 0, state IDLE, synchronisers 0, `IO_IRQ` = 0.
- A reset asserted mid-handshake or mid-transfer returns everything to these values immediately.

## Timing
- Reads: `HRDATA` is registered from the address phase, so data is valid in the data phase with zero wait states. A pop takes effect at that same edge.
- A face write is visible on `IO_FACES` one cycle after the data phase.
- A CTRL write drives `IO_START` high on the edge ending the data phase.
- `IO_ACK` to `IO_START` low / `IO_DONE` high: 1 cycle.
- PMOD strobe edge to FIFO entry: 3 cycles; to STATUS.count visible: 4 cycles.
- `IO_MOVE_VLD` must stay high for at least 2 HCLK and low for at least 2 HCLK between moves.

## Configuration
- `MFP_CUBE_READBACK_EN`
  - Defined: FACE[i] registers read back as stored.
  - Undefined: FACE reads return 0 and the read mux covers only STATUS and MOVE, which saves LUTs.
- Writes, outputs and all other behaviour are identical in both builds.

## Test plan
- Reset → `IO_FACES` face 2 = 0x2492492 (all stickers 3'b010); STATUS = 0; `HRDATA` = 0.
- Write FACE[4] = 0xFFFFFFFF → FACE[4] reads 0x07FFFFFF (with READBACK_EN); without READBACK_EN the same read returns 0; `IO_FACES` slice updates one cycle after the data phase.
- CTRL = 1 → `IO_START` = 1, BUSY = 1; a second CTRL = 1 changes nothing; `IO_ACK` pulse → `IO_START` = 0, DONE = 1, `IO_IRQ` = 1; CTRL = 2 → DONE = 0.
- Push 3 moves (0x05, 0x1A, 0x11) on PMOD → count = 3; three MOVE reads return 0x80000005, 0x8000001A, 0x80000011; a fourth read returns 0.
- Push 9 moves with depth 8 → count = 8, OVF = 1, 9th dropped; CTRL = 4 → count = 0, OVF = 0.
- FIFO full plus simultaneous PMOD push and MOVE read → oldest entry returned, count stays 8, OVF stays 0.
